// File: rtl/div_unit_if.sv
// Request/response bundle between the EXE stage (master) and the divider (slave).
// The divider returns {remainder, quotient} for the HI/LO write.
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic [1:0]          div_op;
  logic [DATA_W-1:0]   dividend;
  logic [DATA_W-1:0]   divisor;
  logic                div_in_valid;
  logic                div_out_ready;
  logic [2*DATA_W-1:0] div_result;
  logic                div_out_valid;
  logic                div_busy;

  modport master (
    output div_op,
    output dividend,
    output divisor,
    output div_in_valid,
    output div_out_ready,
    input  div_result,
    input  div_out_valid,
    input  div_busy
  );

  modport slave (
    input  div_op,
    input  dividend,
    input  divisor,
    input  div_in_valid,
    input  div_out_ready,
    output div_result,
    output div_out_valid,
    output div_busy
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// one operation in flight, result held in DONE until the consumer takes it.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  div_unit_if.slave   div_if
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    count_q;
  logic [DATA_W-1:0]   rem_q;
  logic [DATA_W-1:0]   quo_q;
  logic [DATA_W-1:0]   dvsr_q;
  logic [DATA_W-1:0]   dvnd_raw_q;
  logic                neg_quo_q;
  logic                neg_rem_q;
  logic                zero_q;
  logic [2*DATA_W-1:0] result_q;
  logic                valid_q;
  logic                busy_q;

  // Operand conditioning at accept time; bit 0 of div_op selects signed mode.
  logic                is_signed;
  logic                dvnd_neg;
  logic                dvsr_neg;
  logic [DATA_W-1:0]   dvnd_abs;
  logic [DATA_W-1:0]   dvsr_abs;
  logic                start;

  assign is_signed = div_if.div_op[0];
  assign dvnd_neg  = is_signed & div_if.dividend[DATA_W-1];
  assign dvsr_neg  = is_signed & div_if.divisor[DATA_W-1];
  assign dvnd_abs  = dvnd_neg ? (~div_if.dividend + 1'b1) : div_if.dividend;
  assign dvsr_abs  = dvsr_neg ? (~div_if.divisor + 1'b1) : div_if.divisor;
  assign start     = div_if.div_in_valid & (|div_if.div_op);

  // One restoring step: the partial remainder gains one dividend bit from the
  // top of quo_q; the extra MSB keeps the compare exact before subtracting.
  logic [DATA_W:0]     rem_shift;
  logic                take;
  logic [DATA_W-1:0]   rem_step;
  logic [DATA_W-1:0]   quo_step;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;
  logic [2*DATA_W-1:0] final_result;

  assign rem_shift = {rem_q, quo_q[DATA_W-1]};
  assign take      = (rem_shift >= {1'b0, dvsr_q});
  assign rem_step  = take ? DATA_W'(rem_shift - {1'b0, dvsr_q}) : rem_shift[DATA_W-1:0];
  assign quo_step  = {quo_q[DATA_W-2:0], take};

  assign quo_fix = neg_quo_q ? (~quo_step + 1'b1) : quo_step;
  assign rem_fix = neg_rem_q ? (~rem_step + 1'b1) : rem_step;

  // Divide-by-zero still runs the full iteration count; only the answer is replaced.
  assign final_result = zero_q ? {dvnd_raw_q, {DATA_W{1'b1}}} : {rem_fix, quo_fix};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      dvnd_raw_q <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_q     <= 1'b0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_BUSY;
            busy_q     <= 1'b1;
            count_q    <= '0;
            rem_q      <= '0;
            quo_q      <= dvnd_abs;
            dvsr_q     <= dvsr_abs;
            dvnd_raw_q <= div_if.dividend;
            zero_q     <= (div_if.divisor == '0);
            neg_quo_q  <= dvnd_neg ^ dvsr_neg;
            neg_rem_q  <= dvnd_neg;
          end
        end
        ST_BUSY: begin
          rem_q   <= rem_step;
          quo_q   <= quo_step;
          count_q <= count_q + CNT_W'(1);
          if (count_q == LAST_CNT) begin
            state_q  <= ST_DONE;
            valid_q  <= 1'b1;
            result_q <= final_result;
          end
        end
        ST_DONE: begin
          // Hold indefinitely under back-pressure; always pass through IDLE after a handshake.
          if (div_if.div_out_ready) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign div_if.div_result    = result_q;
  assign div_if.div_out_valid = valid_q;
  assign div_if.div_busy      = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, multi-cycle corner
// sequences and randomized operations against a plain-arithmetic model.
module tb_div_unit;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  div_unit_if #(.DATA_W(32)) dif ();

  div_unit #(.DATA_W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .div_if (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: MIPS-style truncating division, computed with wide integers.
  function automatic logic [63:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [31:0] qu;
    logic [31:0] ru;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      qu = q[31:0];
      ru = r[31:0];
    end else begin
      qu = a / b;
      ru = a % b;
    end
    return {ru, qu};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!dif.div_out_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  // Issue one request, wait for the result, complete the handshake.
  // lat counts clock edges from the request cycle to the first cycle with valid high.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat);
    int n;
    dif.div_op       = op;
    dif.dividend     = a;
    dif.divisor      = b;
    dif.div_in_valid = 1'b1;
    tick();
    dif.div_in_valid = 1'b0;
    wait_valid(n);
    lat = n + 1;
    check("valid_seen", 64'(dif.div_out_valid), 64'd1);
    res = dif.div_result;
    $display("op=%0d %h / %h -> %h (latency %0d)", op, a, b, res, lat);
    dif.div_out_ready = 1'b1;
    tick();
    dif.div_out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] res;
    logic [63:0] held;
    int          lat;
    int          n;
    int          seen;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    n_total = 0;
    n_pass  = 0;

    vecs[0]  = '{2'b01, 32'h0000_0007, 32'h0000_0002, 64'h00000001_00000003};
    vecs[1]  = '{2'b01, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFFFFFF_FFFFFFFD};
    vecs[2]  = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0010, 64'h0000000F_0FFFFFFF};
    vecs[3]  = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000};
    vecs[4]  = '{2'b10, 32'h0000_0005, 32'h0000_0000, 64'h00000005_FFFFFFFF};
    vecs[5]  = '{2'b01, 32'h0000_0007, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD};
    vecs[6]  = '{2'b11, 32'hFFFF_FFF8, 32'h0000_0003, 64'hFFFFFFFE_FFFFFFFE};
    vecs[7]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h80000000_00000000};
    vecs[8]  = '{2'b01, 32'hFFFF_FFFB, 32'h0000_0000, 64'hFFFFFFFB_FFFFFFFF};
    vecs[9]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'h00000001_7FFFFFFC};
    vecs[10] = '{2'b01, 32'h0000_0000, 32'h0000_0005, 64'h00000000_00000000};

    reset             = 1'b1;
    dif.div_op        = 2'b00;
    dif.dividend      = '0;
    dif.divisor       = '0;
    dif.div_in_valid  = 1'b0;
    dif.div_out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_valid",  64'(dif.div_out_valid), 64'd0);
    check("reset_busy",   64'(dif.div_busy),      64'd0);
    check("reset_result", dif.div_result,         64'd0);

    // Directed vector table, including the 33-cycle latency.
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
    end

    // A request with div_op==0 is ignored.
    dif.div_op       = 2'b00;
    dif.dividend     = 32'd9;
    dif.divisor      = 32'd3;
    dif.div_in_valid = 1'b1;
    repeat (3) tick();
    check("op0_busy",  64'(dif.div_busy),      64'd0);
    check("op0_valid", 64'(dif.div_out_valid), 64'd0);
    dif.div_in_valid = 1'b0;
    $display("op=0 request ignored, busy=%0d", dif.div_busy);

    // Operands scrambled while BUSY must not disturb the result.
    dif.div_op       = 2'b01;
    dif.dividend     = 32'd100;
    dif.divisor      = 32'd7;
    dif.div_in_valid = 1'b1;
    tick();
    dif.div_in_valid = 1'b0;
    check("busy_after_accept", 64'(dif.div_busy), 64'd1);
    for (int i = 0; i < 10; i++) begin
      dif.div_op   = 2'($urandom_range(0, 3));
      dif.dividend = $urandom;
      dif.divisor  = $urandom;
      tick();
    end
    wait_valid(n);
    check("scramble_result", dif.div_result, 64'h00000002_0000000E);
    $display("scrambled operands: 100/7 -> %h", dif.div_result);
    dif.div_out_ready = 1'b1;
    tick();
    dif.div_out_ready = 1'b0;

    // Back-pressure: hold 3 cycles, then IDLE, then a still-high request is accepted.
    dif.div_op       = 2'b10;
    dif.dividend     = 32'd20;
    dif.divisor      = 32'd6;
    dif.div_in_valid = 1'b1;
    tick();
    dif.dividend = 32'd9;
    dif.divisor  = 32'd4;
    wait_valid(n);
    check("bp_latency", 64'(n + 1), 64'd33);
    held = dif.div_result;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_hold%0d_valid", i),  64'(dif.div_out_valid), 64'd1);
      check($sformatf("bp_hold%0d_result", i), dif.div_result, 64'h00000002_00000003);
      tick();
    end
    check("bp_still_valid", 64'(dif.div_out_valid), 64'd1);
    dif.div_out_ready = 1'b1;
    tick();
    dif.div_out_ready = 1'b0;
    check("bp_idle_valid",  64'(dif.div_out_valid), 64'd0);
    check("bp_idle_busy",   64'(dif.div_busy),      64'd0);
    check("bp_idle_result", dif.div_result,         held);
    tick();
    check("bp_reaccept_busy", 64'(dif.div_busy), 64'd1);
    dif.div_in_valid = 1'b0;
    wait_valid(n);
    check("bp_second_result",  dif.div_result, 64'h00000001_00000002);
    check("bp_second_latency", 64'(n + 1), 64'd33);
    $display("back-pressure: 20/6 held, then 9/4 -> %h", dif.div_result);
    dif.div_out_ready = 1'b1;
    tick();
    dif.div_out_ready = 1'b0;

    // Reset at BUSY cycle 10 drops the operation.
    dif.div_op       = 2'b01;
    dif.dividend     = 32'd1000;
    dif.divisor      = 32'd3;
    dif.div_in_valid = 1'b1;
    tick();
    dif.div_in_valid = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_valid",  64'(dif.div_out_valid), 64'd0);
    check("midreset_busy",   64'(dif.div_busy),      64'd0);
    check("midreset_result", dif.div_result,         64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (dif.div_out_valid || dif.div_busy) seen++;
      tick();
    end
    check("midreset_no_output", 64'(seen), 64'd0);
    $display("reset mid-operation: op dropped, result=%h", dif.div_result);
    run_op(2'b01, 32'd1000, 32'd3, res, lat);
    check("postreset_result",  res, 64'h00000001_0000014D);
    check("postreset_latency", 64'(lat), 64'd33);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(1, 3));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3:       b = $urandom >> $urandom_range(0, 31);
        4:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op(op, a, b, res, lat);
      check($sformatf("rand%0d_result", i), res, ref_div(op, a, b));
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'd33);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
